// File: rtl/mem_access_pkg.sv
// Shared types for the memory stage: op descriptor, access size and FSM state.
// Consumers: mem_access, mem_access_if, mem_extend.
package mem_access_pkg;

  typedef logic        u1;
  typedef logic [63:0] u64;
  typedef u64          word_t;

  typedef enum logic [1:0] {
    MSIZE_B = 2'd0,
    MSIZE_H = 2'd1,
    MSIZE_W = 2'd2,
    MSIZE_D = 2'd3
  } msize_t;

  typedef struct packed {
    u1      is_load;
    u1      is_store;
    msize_t size;
    u1      is_unsigned;
  } mem_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Number of bytes touched by an access of the given size (1, 2, 4 or 8).
  function automatic logic [3:0] size_bytes(msize_t s);
    return 4'd1 << s;
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Execute-side, writeback-side and data-bus signals of the memory stage.
// master = mem_access itself, slave = the surrounding pipeline and bus.
interface mem_access_if;
  import mem_access_pkg::*;

  u1          in_valid;
  u1          in_ready;
  mem_op_t    in_op;
  word_t      in_result;
  word_t      in_wdata;
  logic [4:0] in_rd;

  u1          out_valid;
  u1          out_ready;
  word_t      out_data;
  logic [4:0] out_rd;
  u1          out_misalign;

  u1          dreq_valid;
  word_t      dreq_addr;
  logic [7:0] dreq_strobe;
  word_t      dreq_data;
  u1          dresp_ok;
  word_t      dresp_data;

  modport master (
    input  in_valid, in_op, in_result, in_wdata, in_rd,
    output in_ready,
    output out_valid, out_data, out_rd, out_misalign,
    input  out_ready,
    output dreq_valid, dreq_addr, dreq_strobe, dreq_data,
    input  dresp_ok, dresp_data
  );

  modport slave (
    output in_valid, in_op, in_result, in_wdata, in_rd,
    input  in_ready,
    input  out_valid, out_data, out_rd, out_misalign,
    output out_ready,
    input  dreq_valid, dreq_addr, dreq_strobe, dreq_data,
    output dresp_ok, dresp_data
  );

endinterface

// File: rtl/mem_access_extend.sv
// mem_extend: pulls the addressed bytes out of an aligned beat and sign/zero
// extends them to a full word. Purely combinational.
module mem_extend
  import mem_access_pkg::*;
(
  input  word_t      word,
  input  logic [2:0] offset,
  input  msize_t     size,
  input  u1          is_unsigned,
  output word_t      result
);

  word_t shifted;
  u1     sext;

  assign shifted = word >> {offset, 3'b000};

  always_comb begin
    result = shifted;
    sext   = 1'b0;
    case (size)
      MSIZE_B: begin
        sext   = ~is_unsigned & shifted[7];
        result = {{56{sext}}, shifted[7:0]};
      end
      MSIZE_H: begin
        sext   = ~is_unsigned & shifted[15];
        result = {{48{sext}}, shifted[15:0]};
      end
      MSIZE_W: begin
        sext   = ~is_unsigned & shifted[31];
        result = {{32{sext}}, shifted[31:0]};
      end
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory stage: single-outstanding data-bus access plus registered writeback.
// Optional MEM_MISALIGN_EN flags size-misaligned accesses instead of issuing them.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int LANES  = DATA_W / 8
) (
  input  logic          clk,
  input  logic          reset,
  mem_access_if.master  bus
);

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [LANES-1:0]  strobe_reg, strobe_next, strobe_calc;
  logic [2:0]        offset_reg, offset_next;
  msize_t            size_reg, size_next;
  u1                 uns_reg, uns_next;
  u1                 load_reg, load_next;
  logic [4:0]        rd_reg, rd_next;

  u1                 out_valid_reg, out_valid_next;
  logic [DATA_W-1:0] out_data_reg, out_data_next;
  logic [4:0]        out_rd_reg, out_rd_next;
  u1                 mis_reg, mis_next;

  u1          accept, is_mem, is_st, mis_det;
  logic [3:0] nbytes;
  word_t      load_data;

  assign bus.in_ready = (state_reg == IDLE) && (!out_valid_reg || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign is_mem       = bus.in_op.is_load || bus.in_op.is_store;
  assign is_st        = bus.in_op.is_store && !bus.in_op.is_load;
  assign nbytes       = size_bytes(bus.in_op.size);

`ifdef MEM_MISALIGN_EN
  logic [3:0] low_mask;
  assign low_mask = nbytes - 4'd1;
  assign mis_det  = is_mem && ((bus.in_result[2:0] & low_mask[2:0]) != 3'd0);
`else
  assign mis_det = 1'b0;
`endif

  // Lane gi is enabled when it falls inside [offset, offset+nbytes); lanes past
  // the top of the beat are simply dropped.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_strobe
      localparam logic [3:0] LANE = 4'(gi);
      assign strobe_calc[gi] = is_st
                            && ({1'b0, bus.in_result[2:0]} <= LANE)
                            && ((LANE - {1'b0, bus.in_result[2:0]}) < nbytes);
    end
  endgenerate

  mem_extend u_extend (
    .word        (bus.dresp_data),
    .offset      (offset_reg),
    .size        (size_reg),
    .is_unsigned (uns_reg),
    .result      (load_data)
  );

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    strobe_next    = strobe_reg;
    offset_next    = offset_reg;
    size_next      = size_reg;
    uns_next       = uns_reg;
    load_next      = load_reg;
    rd_next        = rd_reg;
    out_valid_next = out_valid_reg && !bus.out_ready;
    out_data_next  = out_data_reg;
    out_rd_next    = out_rd_reg;
    mis_next       = mis_reg;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (is_mem && !mis_det) begin
            state_next  = BUS;
            addr_next   = {bus.in_result[DATA_W-1:3], 3'b000};
            wdata_next  = bus.in_wdata << {bus.in_result[2:0], 3'b000};
            strobe_next = strobe_calc;
            offset_next = bus.in_result[2:0];
            size_next   = bus.in_op.size;
            uns_next    = bus.in_op.is_unsigned;
            load_next   = bus.in_op.is_load;
            rd_next     = bus.in_rd;
          end else begin
            // Non-memory op (or flagged misaligned op) retires next cycle.
            out_valid_next = 1'b1;
            out_data_next  = bus.in_result;
            out_rd_next    = bus.in_rd;
            mis_next       = mis_det;
          end
        end
      end
      BUS: begin
        if (bus.dresp_ok) begin
          state_next     = HOLD;
          out_valid_next = 1'b1;
          out_data_next  = load_reg ? load_data : '0;
          out_rd_next    = rd_reg;
          mis_next       = 1'b0;
        end
      end
      HOLD: begin
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      strobe_reg    <= '0;
      offset_reg    <= '0;
      size_reg      <= MSIZE_B;
      uns_reg       <= 1'b0;
      load_reg      <= 1'b0;
      rd_reg        <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_rd_reg    <= '0;
      mis_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      strobe_reg    <= strobe_next;
      offset_reg    <= offset_next;
      size_reg      <= size_next;
      uns_reg       <= uns_next;
      load_reg      <= load_next;
      rd_reg        <= rd_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_rd_reg    <= out_rd_next;
      mis_reg       <= mis_next;
    end
  end

  assign bus.dreq_valid   = (state_reg == BUS);
  assign bus.dreq_addr    = addr_reg;
  assign bus.dreq_strobe  = strobe_reg;
  assign bus.dreq_data    = wdata_reg;
  assign bus.out_valid    = out_valid_reg;
  assign bus.out_data     = out_data_reg;
  assign bus.out_rd       = out_rd_reg;
  assign bus.out_misalign = mis_reg;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: stimulus pushes expected writeback records,
// an independent monitor pops and compares on each writeback handshake.
module tb_mem_access;
  import mem_access_pkg::*;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  rd;
    logic        mis;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];

  mem_access_if bus_if();

  mem_access dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired", name);
  endtask

  function automatic mem_op_t mk_op(input bit l, input bit s, input msize_t sz, input bit u);
    mem_op_t o;
    o.is_load = l;
    o.is_store = s;
    o.size = sz;
    o.is_unsigned = u;
    return o;
  endfunction

  function automatic exp_t mk_exp(input logic [63:0] d, input logic [4:0] rd, input logic mis);
    exp_t e;
    e.data = d;
    e.rd = rd;
    e.mis = mis;
    return e;
  endfunction

  // Called shortly after a posedge; returns #1 after the accepting edge.
  task automatic issue(input mem_op_t op, input logic [63:0] res, input logic [63:0] wd, input logic [4:0] rd);
    int t;
    bus_if.in_valid = 1'b1;
    bus_if.in_op = op;
    bus_if.in_result = res;
    bus_if.in_wdata = wd;
    bus_if.in_rd = rd;
    t = 0;
    while (1) begin
      @(negedge clk);
      if (bus_if.in_ready) break;
      t++;
      if (t > 50) begin
        fail_now("issue_timeout");
        break;
      end
    end
    @(posedge clk);
    #1;
    bus_if.in_valid = 1'b0;
    $display("issue op=%b result=0x%0h wdata=0x%0h rd=%0d", op, res, wd, rd);
  endtask

  task automatic respond(input int waits, input logic [63:0] rdata, input logic [63:0] eaddr,
                         input logic [7:0] estb, input logic [63:0] edata);
    int t;
    t = 0;
    while (1) begin
      @(negedge clk);
      if (bus_if.dreq_valid) break;
      t++;
      if (t > 50) begin
        fail_now("dreq_timeout");
        break;
      end
    end
    chk("dreq_addr", bus_if.dreq_addr, eaddr);
    chk("dreq_strobe", 64'(bus_if.dreq_strobe), 64'(estb));
    chk("dreq_data", bus_if.dreq_data, edata);
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      chk("dreq_hold_valid", 64'(bus_if.dreq_valid), 64'd1);
      chk("dreq_hold_addr", bus_if.dreq_addr, eaddr);
      chk("dreq_hold_strobe", 64'(bus_if.dreq_strobe), 64'(estb));
      chk("dreq_hold_data", bus_if.dreq_data, edata);
    end
    bus_if.dresp_ok = 1'b1;
    bus_if.dresp_data = rdata;
    @(posedge clk);
    #1;
    bus_if.dresp_ok = 1'b0;
    $display("bus addr=0x%0h strobe=0x%0h resp=0x%0h after %0d waits", eaddr, estb, rdata, waits);
  endtask

  task automatic gap();
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Writeback monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && bus_if.out_valid && bus_if.out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL wb_unexpected: got data=0x%0h rd=%0d expected no record", bus_if.out_data, bus_if.out_rd);
        end else begin
          e = sb.pop_front();
          chk("wb_data", bus_if.out_data, e.data);
          chk("wb_rd", 64'(bus_if.out_rd), 64'(e.rd));
          chk("wb_misalign", 64'(bus_if.out_misalign), 64'(e.mis));
          $display("wb data=0x%0h rd=%0d mis=%0d", bus_if.out_data, bus_if.out_rd, bus_if.out_misalign);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.in_valid = 1'b0;
    bus_if.in_op = mk_op(0, 0, MSIZE_B, 0);
    bus_if.in_result = '0;
    bus_if.in_wdata = '0;
    bus_if.in_rd = '0;
    bus_if.out_ready = 1'b1;
    bus_if.dresp_ok = 1'b0;
    bus_if.dresp_data = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(bus_if.out_valid), 64'd0);
    chk("rst_out_data", bus_if.out_data, 64'd0);
    chk("rst_out_rd", 64'(bus_if.out_rd), 64'd0);
    chk("rst_misalign", 64'(bus_if.out_misalign), 64'd0);
    chk("rst_dreq_valid", 64'(bus_if.dreq_valid), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(bus_if.in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Non-memory op: one-cycle latency, no bus activity.
    sb.push_back(mk_exp(64'h1234, 5'd5, 1'b0));
    issue(mk_op(0, 0, MSIZE_D, 0), 64'h1234, 64'h0, 5'd5);
    @(negedge clk);
    chk("nm_out_valid", 64'(bus_if.out_valid), 64'd1);
    chk("nm_dreq_valid", 64'(bus_if.dreq_valid), 64'd0);
    gap();

    // Back-to-back non-memory ops.
    sb.push_back(mk_exp(64'hA1, 5'd1, 1'b0));
    sb.push_back(mk_exp(64'hB2, 5'd2, 1'b0));
    issue(mk_op(0, 0, MSIZE_D, 0), 64'hA1, 64'h0, 5'd1);
    issue(mk_op(0, 0, MSIZE_D, 0), 64'hB2, 64'h0, 5'd2);
    gap();

    // Signed and unsigned byte load at 0x1003.
    sb.push_back(mk_exp(64'hFFFF_FFFF_FFFF_FF80, 5'd7, 1'b0));
    issue(mk_op(1, 0, MSIZE_B, 0), 64'h1003, 64'h0, 5'd7);
    respond(3, 64'h0000_0000_8000_0000, 64'h1000, 8'h00, 64'h0);
    gap();
    sb.push_back(mk_exp(64'h80, 5'd8, 1'b0));
    issue(mk_op(1, 0, MSIZE_B, 1), 64'h1003, 64'h0, 5'd8);
    respond(3, 64'h0000_0000_8000_0000, 64'h1000, 8'h00, 64'h0);
    gap();

    // Halfword store at 0x2006.
    sb.push_back(mk_exp(64'h0, 5'd9, 1'b0));
    issue(mk_op(0, 1, MSIZE_H, 0), 64'h2006, 64'hABCD, 5'd9);
    respond(2, 64'hDEAD, 64'h2000, 8'hC0, 64'hABCD_0000_0000_0000);
    gap();

    // Doubleword load with writeback stalled for 4 cycles.
    bus_if.out_ready = 1'b0;
    sb.push_back(mk_exp(64'h1122_3344_5566_7788, 5'd10, 1'b0));
    issue(mk_op(1, 0, MSIZE_D, 0), 64'h4000, 64'h0, 5'd10);
    respond(1, 64'h1122_3344_5566_7788, 64'h4000, 8'h00, 64'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 64'(bus_if.out_valid), 64'd1);
      chk("bp_out_data", bus_if.out_data, 64'h1122_3344_5566_7788);
      chk("bp_in_ready", 64'(bus_if.in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    bus_if.out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_release_in_ready", 64'(bus_if.in_ready), 64'd1);
    gap();

    // Word load at 0x3002: flagged, or issued and sign-extended from lanes 2..5.
`ifdef MEM_MISALIGN_EN
    sb.push_back(mk_exp(64'h3002, 5'd11, 1'b1));
    issue(mk_op(1, 0, MSIZE_W, 0), 64'h3002, 64'h0, 5'd11);
    @(negedge clk);
    chk("mis_dreq_valid", 64'(bus_if.dreq_valid), 64'd0);
    chk("mis_out_valid", 64'(bus_if.out_valid), 64'd1);
`else
    sb.push_back(mk_exp(64'hFFFF_FFFF_8765_4321, 5'd11, 1'b0));
    issue(mk_op(1, 0, MSIZE_W, 0), 64'h3002, 64'h0, 5'd11);
    respond(0, 64'h0000_8765_4321_0000, 64'h3000, 8'h00, 64'h0);
`endif
    gap();

    // Stray dresp_ok while idle must be ignored.
    bus_if.dresp_ok = 1'b1;
    bus_if.dresp_data = 64'h5555;
    @(posedge clk);
    #1;
    bus_if.dresp_ok = 1'b0;
    @(negedge clk);
    chk("stray_out_valid", 64'(bus_if.out_valid), 64'd0);
    chk("stray_dreq_valid", 64'(bus_if.dreq_valid), 64'd0);
    gap();

    // Reset while a request is open abandons it.
    issue(mk_op(1, 0, MSIZE_D, 0), 64'h5000, 64'h0, 5'd4);
    @(negedge clk);
    chk("bus_open", 64'(bus_if.dreq_valid), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rbus_dreq_valid", 64'(bus_if.dreq_valid), 64'd0);
    chk("rbus_out_valid", 64'(bus_if.out_valid), 64'd0);
    chk("rbus_in_ready", 64'(bus_if.in_ready), 64'd1);
    @(posedge clk);
    #1;
    sb.push_back(mk_exp(64'h55, 5'd3, 1'b0));
    issue(mk_op(0, 0, MSIZE_D, 0), 64'h55, 64'h0, 5'd3);
    gap();

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    chk("sb_drain", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
